// File: rtl/pll_reset_seq.sv
// pll_reset_seq: lock-qualified reset sequencer driving PLL RESET and releasing sys_rst after stable lock.
// Runs on the PLL reference clock so it keeps sequencing while the PLL output is absent.
module pll_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 270000,
    parameter int STABLE_CYCLES = 2700,
    parameter int RETRY_W       = 4
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);
    localparam int M1      = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = M1 > STABLE_CYCLES ? M1 : STABLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [1:0]      sync;
    logic            lock_s, retry_inc, lost_set;

    assign lock_s    = sync[1];
    assign pll_reset = state == PLL_RST;
    assign sys_rst   = state != RUN;
    assign ready     = state == RUN;

    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= PLL_RST;
            cnt       <= '0;
            sync      <= '0;
            lock_lost <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sync      <= {sync[0], pll_lock};
            lock_lost <= lock_lost | lost_set;
            if (retry_inc && !(&retry_cnt)) retry_cnt <= retry_cnt + 1'b1;
        end
    end

    // Every transition restarts the shared counter from zero.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 1'b1;
        retry_inc = 1'b0;
        lost_set  = 1'b0;
        case (state)
            PLL_RST: if (cnt == CW'(RST_CYCLES - 1)) begin
                state_nx = WAIT_LOCK;
                cnt_nx   = '0;
            end
            WAIT_LOCK: if (lock_s) begin
                state_nx = STABLE;
                cnt_nx   = '0;
            end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                state_nx  = PLL_RST;
                cnt_nx    = '0;
                retry_inc = 1'b1;
            end
            STABLE: if (!lock_s) begin
                state_nx = WAIT_LOCK;
                cnt_nx   = '0;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
            RUN: begin
                cnt_nx = '0;
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    lost_set = 1'b1;
                end
            end
        endcase
    end
endmodule
